// File: rtl/dmem_result_checker.sv
// dmem_result_checker
// End-of-run result checker for the single-cycle RISC-V core. After the CPU
// raises `done` (or a cycle timeout expires) it walks DEPTH consecutive data
// memory words starting at BASE_ADDR, compares each against an expected-value
// source and reports a verdict.
//
// Ports
//   clk, reset       : clock, synchronous active-high reset
//   done             : CPU completion flag (sampled only while waiting)
//   chk_addr         : byte address driven to the dmem read port
//   chk_rdata        : dmem read data (READ_LAT cycles after chk_addr)
//   exp_idx          : word index driven to the expected-value source
//   exp_data         : expected word for exp_idx, same cycle
//   busy             : scan in progress
//   finished         : verdict valid, held until reset
//   pass             : finished with zero mismatches
//   timed_out        : scan was started by the timeout rather than done
//   fail_count       : number of mismatching words
//   first_fail_idx   : index of the first mismatch (0 if none)
//   first_fail_got   : dmem value at the first mismatch (0 if none)
//   dbg_state        : current FSM state (WAIT=0, SCAN=1, DRAIN=2, DONE=3)
//
// Handshake: there is no backpressure. Each cycle in SCAN the issue stage
// presents one (chk_addr, exp_idx) pair and the compare stage consumes the
// chk_rdata that belongs to the pair issued READ_LAT cycles earlier.
module dmem_result_checker #(
    parameter int          WIDTH        = 32,
    parameter int          DEPTH        = 32,
    parameter logic [31:0] BASE_ADDR    = 32'h0,
    parameter int          TIMEOUT      = 200,
    parameter int          READ_LAT     = 0,
    parameter int          STOP_ON_FAIL = 0,
    localparam int         CW           = $clog2(DEPTH + 1),
    localparam int         IW           = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             done,
    output logic [31:0]      chk_addr,
    input  logic [WIDTH-1:0] chk_rdata,
    output logic [IW-1:0]    exp_idx,
    input  logic [WIDTH-1:0] exp_data,
    output logic             busy,
    output logic             finished,
    output logic             pass,
    output logic             timed_out,
    output logic [CW-1:0]    fail_count,
    output logic [IW-1:0]    first_fail_idx,
    output logic [WIDTH-1:0] first_fail_got,
    output logic [1:0]       dbg_state
);

    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q;
    logic [TW-1:0]    cnt_q;
    logic [IW-1:0]    iss_idx_q;
    logic             iss_valid_q;
    logic [31:0]      chk_addr_q;
    logic             busy_q;
    logic             finished_q;
    logic             pass_q;
    logic             timed_out_q;
    logic [CW-1:0]    fail_count_q;
    logic [IW-1:0]    first_fail_idx_q;
    logic [WIDTH-1:0] first_fail_got_q;

    // Compare stage view: which word is being checked this cycle.
    logic             c_valid;
    logic [IW-1:0]    c_idx;
    logic [WIDTH-1:0] c_exp;
    logic             c_mismatch;
    logic             c_last;
    logic             stop;

    generate
        if (READ_LAT == 0) begin : g_lat0
            // Combinational read: the issued word is compared in the same cycle.
            assign c_valid = (state_q == S_SCAN) && iss_valid_q;
            assign c_idx   = iss_idx_q;
            assign c_exp   = exp_data;
        end else begin : g_lat1
            // Registered read: carry index and expected word one cycle so they
            // line up with the data returning from dmem.
            logic             cmp_valid_q;
            logic [IW-1:0]    cmp_idx_q;
            logic [WIDTH-1:0] cmp_exp_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    cmp_valid_q <= 1'b0;
                    cmp_idx_q   <= '0;
                    cmp_exp_q   <= '0;
                end else begin
                    // A stopping mismatch discards the word already in flight.
                    cmp_valid_q <= (state_q == S_SCAN) && iss_valid_q && !stop;
                    cmp_idx_q   <= iss_idx_q;
                    cmp_exp_q   <= exp_data;
                end
            end

            assign c_valid = (state_q == S_SCAN) && cmp_valid_q;
            assign c_idx   = cmp_idx_q;
            assign c_exp   = cmp_exp_q;
        end
    endgenerate

    // 4-state inequality: an X/Z bit in the read data counts as a mismatch.
    assign c_mismatch = c_valid && (chk_rdata !== c_exp);
    assign c_last     = c_valid && (c_idx == LAST_IDX);
    assign stop       = (STOP_ON_FAIL != 0) && c_mismatch;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_WAIT;
            cnt_q            <= '0;
            iss_idx_q        <= '0;
            iss_valid_q      <= 1'b0;
            chk_addr_q       <= BASE_ADDR;
            busy_q           <= 1'b0;
            finished_q       <= 1'b0;
            pass_q           <= 1'b0;
            timed_out_q      <= 1'b0;
            fail_count_q     <= '0;
            first_fail_idx_q <= '0;
            first_fail_got_q <= '0;
        end else begin
            case (state_q)
                S_WAIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    // done has priority when it coincides with the timeout.
                    if (done || (cnt_q == TO_LAST)) begin
                        state_q     <= S_SCAN;
                        busy_q      <= 1'b1;
                        iss_valid_q <= 1'b1;
                        timed_out_q <= !done;
                    end
                end
                S_SCAN: begin
                    if (c_mismatch) begin
                        fail_count_q <= fail_count_q + 1'b1;
                        if (fail_count_q == '0) begin
                            first_fail_idx_q <= c_idx;
                            first_fail_got_q <= chk_rdata;
                        end
                    end
                    // Advance the issue pointer; it never wraps past the window,
                    // and it holds on a stopping mismatch so no further address
                    // is presented.
                    if (iss_valid_q && !stop) begin
                        if (iss_idx_q == LAST_IDX) begin
                            iss_valid_q <= 1'b0;
                        end else begin
                            iss_idx_q  <= iss_idx_q + 1'b1;
                            chk_addr_q <= chk_addr_q + 32'd4;
                        end
                    end
                    if (stop || c_last) begin
                        state_q     <= S_DRAIN;
                        iss_valid_q <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    // Last compare has been recorded; publish the verdict.
                    state_q    <= S_DONE;
                    busy_q     <= 1'b0;
                    finished_q <= 1'b1;
                    pass_q     <= (fail_count_q == '0);
                end
                S_DONE: begin
                    state_q <= S_DONE;
                end
                default: begin
                    state_q <= S_WAIT;
                end
            endcase
        end
    end

    assign chk_addr       = chk_addr_q;
    assign exp_idx        = iss_idx_q;
    assign busy           = busy_q;
    assign finished       = finished_q;
    assign pass           = pass_q;
    assign timed_out      = timed_out_q;
    assign fail_count     = fail_count_q;
    assign first_fail_idx = first_fail_idx_q;
    assign first_fail_got = first_fail_got_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_dmem_result_checker.sv
// Bench for dmem_result_checker. Three instances cover the default
// configuration (u0), registered read with an offset window (u1) and
// stop-on-first-failure (u2). Each has its own memory and expected array.
module tb_dmem_result_checker;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset0, reset1, reset2;
    logic done0, done1, done2;

    // ---------------- u0: defaults ----------------
    logic [31:0] mem0 [32];
    logic [31:0] expv0[32];
    logic [31:0] chk_addr0;
    logic [31:0] rdata0, expd0, ffg0;
    logic [4:0]  exp_idx0, ffi0;
    logic [5:0]  fcnt0;
    logic        busy0, fin0, pass0, to0;
    logic [1:0]  st0;

    assign rdata0 = mem0[chk_addr0[6:2]];
    assign expd0  = expv0[exp_idx0];

    dmem_result_checker u0 (
        .clk(clk), .reset(reset0), .done(done0),
        .chk_addr(chk_addr0), .chk_rdata(rdata0),
        .exp_idx(exp_idx0), .exp_data(expd0),
        .busy(busy0), .finished(fin0), .pass(pass0), .timed_out(to0),
        .fail_count(fcnt0), .first_fail_idx(ffi0), .first_fail_got(ffg0),
        .dbg_state(st0)
    );

    // ---------------- u1: READ_LAT=1, DEPTH=8, BASE 0x40 ----------------
    logic [31:0] mem1 [8];
    logic [31:0] expv1[8];
    logic [31:0] chk_addr1;
    logic [31:0] rdata1, expd1, ffg1;
    logic [2:0]  exp_idx1, ffi1;
    logic [3:0]  fcnt1;
    logic        busy1, fin1, pass1, to1;
    logic [1:0]  st1;

    always @(posedge clk) rdata1 <= mem1[chk_addr1[4:2]];
    assign expd1 = expv1[exp_idx1];

    dmem_result_checker #(.DEPTH(8), .BASE_ADDR(32'h40), .READ_LAT(1)) u1 (
        .clk(clk), .reset(reset1), .done(done1),
        .chk_addr(chk_addr1), .chk_rdata(rdata1),
        .exp_idx(exp_idx1), .exp_data(expd1),
        .busy(busy1), .finished(fin1), .pass(pass1), .timed_out(to1),
        .fail_count(fcnt1), .first_fail_idx(ffi1), .first_fail_got(ffg1),
        .dbg_state(st1)
    );

    // ---------------- u2: STOP_ON_FAIL=1, DEPTH=8 ----------------
    logic [31:0] mem2 [8];
    logic [31:0] expv2[8];
    logic [31:0] chk_addr2;
    logic [31:0] rdata2, expd2, ffg2;
    logic [2:0]  exp_idx2, ffi2;
    logic [3:0]  fcnt2;
    logic        busy2, fin2, pass2, to2;
    logic [1:0]  st2;

    assign rdata2 = mem2[chk_addr2[4:2]];
    assign expd2  = expv2[exp_idx2];

    dmem_result_checker #(.DEPTH(8), .STOP_ON_FAIL(1)) u2 (
        .clk(clk), .reset(reset2), .done(done2),
        .chk_addr(chk_addr2), .chk_rdata(rdata2),
        .exp_idx(exp_idx2), .exp_data(expd2),
        .busy(busy2), .finished(fin2), .pass(pass2), .timed_out(to2),
        .fail_count(fcnt2), .first_fail_idx(ffi2), .first_fail_got(ffg2),
        .dbg_state(st2)
    );

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] pop_exp();
        if (exp_q.size() == 0) return 'x;
        return exp_q.pop_front();
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset0(input string tag);
        check({tag, ".busy"},      busy0,     0);
        check({tag, ".finished"},  fin0,      0);
        check({tag, ".pass"},      pass0,     0);
        check({tag, ".timed_out"}, to0,       0);
        check({tag, ".fail_count"}, fcnt0,    0);
        check({tag, ".ffi"},       ffi0,      0);
        check({tag, ".ffg"},       ffg0,      0);
        check({tag, ".chk_addr"},  chk_addr0, 0);
        check({tag, ".exp_idx"},   exp_idx0,  0);
        check({tag, ".state"},     st0,       0);
    endtask

    task automatic check_verdict0(input string tag);
        check({tag, ".pass"},       pass0, pop_exp());
        check({tag, ".fail_count"}, fcnt0, pop_exp());
        check({tag, ".timed_out"},  to0,   pop_exp());
        check({tag, ".ffi"},        ffi0,  pop_exp());
        check({tag, ".ffg"},        ffg0,  pop_exp());
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] max_addr;

        for (int i = 0; i < 32; i++) begin
            mem0[i]  = i * 3;
            expv0[i] = i * 3;
        end
        for (int i = 0; i < 8; i++) begin
            mem1[i]  = 32'h100 + i * 7;
            expv1[i] = 32'h100 + i * 7;
            mem2[i]  = 32'hA0 + i;
            expv2[i] = 32'hA0 + i;
        end
        mem2[3] = 32'h0BAD_F00D;
        mem2[5] = 32'h0000_1234;

        reset0 = 1'b1; reset1 = 1'b1; reset2 = 1'b1;
        done0 = 1'b0; done1 = 1'b0; done2 = 1'b0;
        tick(2);
        check_reset0("rst");
        check("rst.u1.chk_addr", chk_addr1, 32'h40);

        // --- clean scan, done before edge 50 after reset release ---
        reset0 = 1'b0;
        tick(49);
        done0 = 1'b1;
        tick(1);
        done0 = 1'b0;
        check("t1.busy_rise", busy0, 1);
        check("t1.fin_early", fin0, 0);
        tick(32);
        check("t1.fin_at_82", fin0, 0);
        check("t1.busy_at_82", busy0, 1);
        tick(1);
        check("t1.fin_at_83", fin0, 1);
        check("t1.busy_fall", busy0, 0);
        exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(0);
        exp_q.push_back(0); exp_q.push_back(0);
        check_verdict0("t1");

        // --- two corrupted words, timeout trigger ---
        reset0 = 1'b1;
        tick(1);
        mem0[5]  = 32'hDEADBEEF;
        mem0[17] = 32'hDEADBEEF;
        reset0 = 1'b0;
        tick(199);
        check("t2.busy_pre_to", busy0, 0);
        tick(1);
        check("t2.busy_at_to", busy0, 1);
        check("t2.timed_out", to0, 1);
        tick(32);
        check("t2.fin_at_232", fin0, 0);
        tick(1);
        check("t2.fin_at_233", fin0, 1);
        exp_q.push_back(0); exp_q.push_back(2); exp_q.push_back(1);
        exp_q.push_back(5); exp_q.push_back(32'hDEADBEEF);
        check_verdict0("t2");

        // --- done exactly on the timeout cycle, then reset mid-scan ---
        reset0 = 1'b1;
        tick(1);
        mem0[5]  = 5 * 3;
        mem0[17] = 17 * 3;
        reset0 = 1'b0;
        tick(199);
        done0 = 1'b1;
        tick(1);
        done0 = 1'b0;
        check("t5.timed_out", to0, 0);
        check("t5.busy", busy0, 1);
        tick(10);
        check("t5.word10_idx", exp_idx0, 10);
        check("t5.word10_addr", chk_addr0, 32'h28);
        reset0 = 1'b1;
        tick(1);
        check_reset0("t5.midrst");
        reset0 = 1'b0;
        tick(3);
        done0 = 1'b1;
        tick(1);
        done0 = 1'b0;
        tick(33);
        check("t5.rescan_fin", fin0, 1);
        exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(0);
        exp_q.push_back(0); exp_q.push_back(0);
        check_verdict0("t5.rescan");

        // --- READ_LAT=1 address sequence and alignment ---
        reset1 = 1'b0;
        tick(4);
        done1 = 1'b1;
        tick(1);
        done1 = 1'b0;
        for (int i = 0; i < 8; i++) exp_q.push_back(32'h40 + 4 * i);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t3.addr%0d", i), chk_addr1, pop_exp());
            tick(1);
        end
        check("t3.fin_at_8", fin1, 0);
        tick(1);
        check("t3.fin_at_9", fin1, 0);
        tick(1);
        check("t3.fin_at_10", fin1, 1);
        check("t3.pass", pass1, 1);
        check("t3.fail_count", fcnt1, 0);

        // --- STOP_ON_FAIL with mismatch at word 3 ---
        reset2 = 1'b0;
        tick(3);
        done2 = 1'b1;
        tick(1);
        done2 = 1'b0;
        max_addr = chk_addr2;
        for (int k = 0; k < 4; k++) begin
            tick(1);
            if (chk_addr2 > max_addr) max_addr = chk_addr2;
        end
        check("t4.fin_early", fin2, 0);
        tick(1);
        if (chk_addr2 > max_addr) max_addr = chk_addr2;
        check("t4.fin", fin2, 1);
        check("t4.fail_count", fcnt2, 1);
        check("t4.ffi", ffi2, 3);
        check("t4.ffg", ffg2, 32'h0BAD_F00D);
        check("t4.pass", pass2, 0);
        check("t4.max_addr", max_addr, 32'h0C);
        // Verdict must stay frozen regardless of done activity.
        done2 = 1'b1;
        tick(3);
        done2 = 1'b0;
        tick(1);
        check("t4.frozen_fin", fin2, 1);
        check("t4.frozen_cnt", fcnt2, 1);
        check("t4.frozen_addr", chk_addr2, 32'h0C);

        check("sb.empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_result_checker.md
# dmem_result_checker

Synthesizable end-of-run result checker for the single-cycle RISC-V core. It waits for the CPU's `done` or a cycle timeout, then walks a parametrised window of data memory word by word through a read port. Each word is compared against an expected-value source, and the block reports a pass/fail verdict, a mismatch count and the first failing word. It sits beside `dmem` and `control`, so regression checking can move from bench-only code into hardware (FPGA bring-up, self-checking sims).

## Interface
Parameters:
- `WIDTH`, 32: data word width in bits.
- `DEPTH`, 32: number of consecutive words checked (≥1).
- `BASE_ADDR`, 32'h0: byte address of word 0; word i is at `BASE_ADDR + 4*i`.
- `TIMEOUT`, 200: cycles after reset release before the scan is forced without `done` (≥1).
- `READ_LAT`, 0: dmem read latency in cycles. 0 means combinational `drdata`; 1 means registered.
- `STOP_ON_FAIL`, 0: 1 ends the scan at the first mismatch.

Ports (`CW = $clog2(DEPTH+1)`, `IW = $clog2(DEPTH)` min 1):
- `clk` in 1: system clock. All state updates on the rising edge.
- `reset` in 1: synchronous, active-high. Clears all state.
- `done` in 1: CPU completion flag, level-sensitive.
- `chk_addr` out 32: byte address to dmem read port.
- `chk_rdata` in WIDTH: dmem read data for `chk_addr`.
- `exp_idx` out IW: index into expected-value source.
- `exp_data` in WIDTH: expected word for `exp_idx`. Combinational, same cycle.
- `busy` out 1: scan in progress.
- `finished` out 1: verdict valid. Held until reset.
- `pass` out 1: `finished` and `fail_count == 0`.
- `timed_out` out 1: scan was triggered by the timeout, not by `done`.
- `fail_count` out CW: number of mismatching words.
- `first_fail_idx` out IW: index of the first mismatch. 0 if none.
- `first_fail_got` out WIDTH: dmem value at the first mismatch. 0 if none.

## Operation
- FSM states:
  - WAIT (after reset): the cycle counter increments each cycle.
    - Go to ISSUE when `done`==1, or when the counter reaches `TIMEOUT-1`.
    - If both occur in the same cycle, `done` wins and `timed_out`=0.
  - ISSUE: drive word index i, with `chk_addr = BASE_ADDR + (i<<2)` and `exp_idx` = i. i starts at 0.
  - COMPARE: compare `chk_rdata` against the expected word captured for the same i. Mismatch uses 4-state inequality semantics in sim; any differing bit counts.
  - DONE: all outputs frozen. Only `reset` leaves this state.
- Pipelining:
  - READ_LAT=0: issue and compare happen in the same cycle, one word per cycle.
  - READ_LAT=1: compare lags issue by one cycle. `exp_data` is registered alongside the index so the pair stays aligned, giving one word per cycle after a 1-cycle fill.
- On a mismatch:
  - `fail_count` += 1.
  - If this is the first mismatch, latch `first_fail_idx` and `first_fail_got`.
- STOP_ON_FAIL=1: the first mismatch moves the FSM to DONE. Any in-flight word is discarded and `fail_count`=1.
- Index does not wrap. The scan ends after the compare of index `DEPTH-1`.
- `done` changes after leaving WAIT are ignored.

## Timing
- Reset values: `busy`=0, `finished`=0, `pass`=0, `timed_out`=0, `fail_count`=0, `first_fail_idx`=0, `first_fail_got`=0, `chk_addr`=BASE_ADDR, `exp_idx`=0. The counter and FSM go to WAIT.
- `reset` asserted in any state, including mid-scan, returns to WAIT on the next edge with all outputs at their reset values.
- `busy` rises on the edge after the trigger and stays high through the last compare.
- `finished` rises on the edge after the last compare. `busy` falls on the same edge.
- Trigger edge to `finished`, full scan: `DEPTH + READ_LAT + 1` cycles.
- Timeout, with no `done`: the trigger fires on the edge where the count equals `TIMEOUT-1`, i.e. `TIMEOUT` cycles after reset release.
- `pass` and `fail_count` are valid only while `finished`=1. During a scan they show running values.

## Test plan
- Defaults, READ_LAT=0. dmem words 0..31 = i*3 and expected = i*3; `done` pulsed at cycle 50. Required: `finished` at cycle 50+33, `pass`=1, `fail_count`=0, `timed_out`=0.
- Words 5 and 17 corrupted (got 32'hDEADBEEF); no `done`, TIMEOUT=200. Required: `timed_out`=1, `fail_count`=2, `first_fail_idx`=5, `first_fail_got`=32'hDEADBEEF, `pass`=0.
- READ_LAT=1, DEPTH=8, BASE_ADDR=32'h40. Required: `chk_addr` sequence 0x40,0x44,…,0x5C; all compares aligned (no false fails); `finished` 10 cycles after trigger.
- STOP_ON_FAIL=1, mismatch at word 3. Required: `finished` once word 3 is compared, `fail_count`=1, `first_fail_idx`=3, no addresses beyond 0x0C issued.
- `done` asserted exactly at cycle TIMEOUT-1. Required: `timed_out`=0. Separately, `reset` pulsed mid-scan at word 10. Required: all outputs at reset values next edge, then a clean rescan to `pass`=1.
